// File: rtl/id_fwd_pkg.sv
// Shared constants, stall-cause encoding and the bypass-select helper for the
// ID-stage operand forwarding and hazard unit.
package id_fwd_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int ADDR_W_DEF = 5;
  localparam int MAX_DEPTH  = 16;
  localparam int SEL_W      = $clog2(MAX_DEPTH);

  typedef enum logic [2:0] {
    NONE     = 3'd0,
    LOAD_USE = 3'd1,
    RAW_LONG = 3'd2,
    WAW_LONG = 3'd3,
    LR_FULL  = 3'd4
  } stall_cause_e;

  typedef struct packed {
    logic             hit;
    logic [SEL_W-1:0] idx;
  } fwd_sel_t;

  // Picks the youngest (lowest-index) downstream stage whose destination matches.
  function automatic fwd_sel_t fwd_select(input logic [MAX_DEPTH-1:0] match);
    fwd_sel_t sel;
    sel = '0;
    for (int k = MAX_DEPTH - 1; k >= 0; k--) begin
      if (match[k]) begin
        sel.hit = 1'b1;
        sel.idx = SEL_W'(k);
      end
    end
    return sel;
  endfunction

endpackage

// File: rtl/id_scoreboard.sv
// Pending-register scoreboard for long-latency (mul/div) results: pending bits,
// outstanding counter, and the set/clear/full decisions.
module id_scoreboard
  import id_fwd_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int LR_MAX = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   set_en,
  input  logic [ADDR_W-1:0]      set_addr,
  input  logic                   done,
  input  logic [ADDR_W-1:0]      done_addr,
  output logic [2**ADDR_W-1:0]   pend_live,
  output logic                   full_block,
  output logic                   lr_full
);

  localparam int NREG  = 2**ADDR_W;
  localparam int CNT_W = $clog2(LR_MAX + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(LR_MAX);

  logic [NREG-1:0]  pending;
  logic [NREG-1:0]  pending_nxt;
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] count_nxt;
  logic             set_ok;
  logic             done_ok;

  // A completion only counts if it retires something we are actually waiting on.
  assign set_ok  = set_en && (set_addr != '0);
  assign done_ok = done && pending[done_addr];

  always_comb begin
    pend_live = pending;
    if (done_ok) pend_live[done_addr] = 1'b0;
  end

  always_comb begin
    pending_nxt = pend_live;
    if (set_ok) pending_nxt[set_addr] = 1'b1;
    count_nxt = count;
    if (set_ok && !done_ok)      count_nxt = count + 1'b1;
    else if (!set_ok && done_ok) count_nxt = count - 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pending <= '0;
      count   <= '0;
    end else begin
      pending <= pending_nxt;
      count   <= count_nxt;
    end
  end

  assign full_block = (count == CNT_MAX) && !done_ok;
  assign lr_full    = rst && (count == CNT_MAX);

endmodule

// File: rtl/id_fwd_scoreboard.sv
// ID-stage operand bypass, load-use/long-latency hazard detection and stall.
// Optional stall statistics counters are built when ID_FWD_STATS_EN is defined.
module id_fwd_scoreboard
  import id_fwd_pkg::*;
#(
  parameter int NUM_RD = 2,
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DEPTH  = 2,
  parameter int LR_MAX = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     id_valid,
  input  logic [NUM_RD-1:0]        id_rd_en,
  input  logic [NUM_RD*ADDR_W-1:0] id_rd_addr,
  input  logic [NUM_RD*DATA_W-1:0] id_rf_data,
  input  logic                     id_wr_en,
  input  logic [ADDR_W-1:0]        id_wr_addr,
  input  logic                     id_is_long,
  input  logic [DEPTH-1:0]         st_wr_en,
  input  logic [DEPTH*ADDR_W-1:0]  st_wr_addr,
  input  logic [DEPTH*DATA_W-1:0]  st_wr_data,
  input  logic [DEPTH-1:0]         st_data_ok,
  input  logic                     lr_done,
  input  logic [ADDR_W-1:0]        lr_done_addr,
  input  logic [DATA_W-1:0]        lr_done_data,
  output logic [NUM_RD*DATA_W-1:0] id_rd_data,
  output logic                     stall,
  output logic                     lr_full,
  output logic [31:0]              stall_cnt,
  output logic [31:0]              lu_stall_cnt
);

  logic [2**ADDR_W-1:0] pend_live;
  logic                 full_block;
  logic [NUM_RD-1:0]    lu_port;
  logic [NUM_RD-1:0]    raw_port;
  logic [4:0]           cause;
  logic                 accept;

  for (genvar p = 0; p < NUM_RD; p++) begin : g_port
    logic [ADDR_W-1:0]    addr;
    logic                 active;
    logic [MAX_DEPTH-1:0] match;
    fwd_sel_t             sel;
    logic [DATA_W-1:0]    stage_data;
    logic                 stage_ok;
    logic [DATA_W-1:0]    data;

    assign addr   = id_rd_addr[p*ADDR_W +: ADDR_W];
    assign active = id_rd_en[p] && (addr != '0);

    always_comb begin
      match = '0;
      for (int k = 0; k < DEPTH; k++)
        match[k] = st_wr_en[k] && (st_wr_addr[k*ADDR_W +: ADDR_W] == addr);
    end

    assign sel = fwd_select(match);

    always_comb begin
      stage_data = '0;
      stage_ok   = 1'b1;
      for (int k = 0; k < DEPTH; k++) begin
        if (int'(sel.idx) == k) begin
          stage_data = st_wr_data[k*DATA_W +: DATA_W];
          stage_ok   = st_data_ok[k];
        end
      end
    end

    always_comb begin
      data = id_rf_data[p*DATA_W +: DATA_W];
      if (!active)                                  data = '0;
      else if (sel.hit)                             data = stage_data;
      else if (lr_done && (lr_done_addr == addr))   data = lr_done_data;
    end

    assign lu_port[p]  = active && sel.hit && !stage_ok;
    assign raw_port[p] = active && pend_live[addr];
    assign id_rd_data[p*DATA_W +: DATA_W] = rst ? data : '0;
  end

  // Each bit of cause is one hazard source; several may be active together.
  always_comb begin
    cause           = '0;
    cause[LOAD_USE] = |lu_port;
    cause[RAW_LONG] = |raw_port;
    cause[WAW_LONG] = id_wr_en && pend_live[id_wr_addr];
    cause[LR_FULL]  = id_wr_en && id_is_long && full_block;
  end

  assign stall  = rst && id_valid && (|cause);
  assign accept = id_valid && !stall;

  id_scoreboard #(
    .ADDR_W (ADDR_W),
    .LR_MAX (LR_MAX)
  ) u_scoreboard (
    .clk        (clk),
    .rst        (rst),
    .set_en     (accept && id_wr_en && id_is_long),
    .set_addr   (id_wr_addr),
    .done       (lr_done),
    .done_addr  (lr_done_addr),
    .pend_live  (pend_live),
    .full_block (full_block),
    .lr_full    (lr_full)
  );

`ifdef ID_FWD_STATS_EN
  logic [31:0] stall_total;
  logic [31:0] lu_total;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_total <= '0;
      lu_total    <= '0;
    end else begin
      if (stall && (stall_total != '1))                    stall_total <= stall_total + 1'b1;
      if (stall && cause[LOAD_USE] && (lu_total != '1))    lu_total    <= lu_total + 1'b1;
    end
  end

  assign stall_cnt    = stall_total;
  assign lu_stall_cnt = lu_total;
`else
  assign stall_cnt    = '0;
  assign lu_stall_cnt = '0;
`endif

endmodule

// File: tb/tb_id_fwd_scoreboard.sv
// Bench for id_fwd_scoreboard: per-cycle vectors with expected outputs queued at
// drive time and compared on the falling edge.
module tb_id_fwd_scoreboard;

  logic        clk = 1'b0;
  logic        rst;
  logic        id_valid;
  logic [1:0]  id_rd_en;
  logic [9:0]  id_rd_addr;
  logic [63:0] id_rf_data;
  logic        id_wr_en;
  logic [4:0]  id_wr_addr;
  logic        id_is_long;
  logic [1:0]  st_wr_en;
  logic [9:0]  st_wr_addr;
  logic [63:0] st_wr_data;
  logic [1:0]  st_data_ok;
  logic        lr_done;
  logic [4:0]  lr_done_addr;
  logic [31:0] lr_done_data;
  logic [63:0] id_rd_data;
  logic        stall;
  logic        lr_full;
  logic [31:0] stall_cnt;
  logic [31:0] lu_stall_cnt;

  always #5 clk = ~clk;

  id_fwd_scoreboard dut (
    .clk          (clk),
    .rst          (rst),
    .id_valid     (id_valid),
    .id_rd_en     (id_rd_en),
    .id_rd_addr   (id_rd_addr),
    .id_rf_data   (id_rf_data),
    .id_wr_en     (id_wr_en),
    .id_wr_addr   (id_wr_addr),
    .id_is_long   (id_is_long),
    .st_wr_en     (st_wr_en),
    .st_wr_addr   (st_wr_addr),
    .st_wr_data   (st_wr_data),
    .st_data_ok   (st_data_ok),
    .lr_done      (lr_done),
    .lr_done_addr (lr_done_addr),
    .lr_done_data (lr_done_data),
    .id_rd_data   (id_rd_data),
    .stall        (stall),
    .lr_full      (lr_full),
    .stall_cnt    (stall_cnt),
    .lu_stall_cnt (lu_stall_cnt)
  );

  typedef struct {
    string       name;
    logic        rst;
    logic        valid;
    logic [1:0]  rd_en;
    logic [4:0]  a0, a1;
    logic [31:0] rf0, rf1;
    logic        wr_en;
    logic [4:0]  wr_addr;
    logic        is_long;
    logic [1:0]  st_en;
    logic [4:0]  s0a, s1a;
    logic [31:0] s0d, s1d;
    logic [1:0]  ok;
    logic        done;
    logic [4:0]  done_addr;
    logic [31:0] done_data;
    logic [31:0] e0, e1;
    logic        estall, efull, elu;
  } vec_t;

  typedef struct {
    string       name;
    logic        rst;
    logic [31:0] e0, e1;
    logic        estall, efull, elu;
  } exp_t;

  exp_t exp_q[$];
  vec_t tbl[$];
  vec_t v;
  exp_t ce;
  int   checks = 0;
  int   failures = 0;
  int   m_stall = 0;
  int   m_lu = 0;

  function automatic vec_t idle(input string n);
    vec_t t;
    t.name = n; t.rst = 1'b1; t.valid = 1'b1; t.rd_en = 2'b00; t.a0 = 5'd0; t.a1 = 5'd0;
    t.rf0 = 32'hAAAA_0000; t.rf1 = 32'hBBBB_0000;
    t.wr_en = 1'b0; t.wr_addr = 5'd0; t.is_long = 1'b0;
    t.st_en = 2'b00; t.s0a = 5'd0; t.s1a = 5'd0; t.s0d = '0; t.s1d = '0; t.ok = 2'b11;
    t.done = 1'b0; t.done_addr = 5'd0; t.done_data = '0;
    t.e0 = '0; t.e1 = '0; t.estall = 1'b0; t.efull = 1'b0; t.elu = 1'b0;
    return t;
  endfunction

  task automatic check(input string n, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", n, act, req);
    end
  endtask

  task automatic apply(input vec_t t);
    exp_t e;
    @(posedge clk);
    #1;
    rst = t.rst; id_valid = t.valid; id_rd_en = t.rd_en;
    id_rd_addr = {t.a1, t.a0}; id_rf_data = {t.rf1, t.rf0};
    id_wr_en = t.wr_en; id_wr_addr = t.wr_addr; id_is_long = t.is_long;
    st_wr_en = t.st_en; st_wr_addr = {t.s1a, t.s0a}; st_wr_data = {t.s1d, t.s0d};
    st_data_ok = t.ok; lr_done = t.done; lr_done_addr = t.done_addr; lr_done_data = t.done_data;
    e.name = t.name; e.rst = t.rst; e.e0 = t.e0; e.e1 = t.e1;
    e.estall = t.estall; e.efull = t.efull; e.elu = t.elu;
    exp_q.push_back(e);
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      ce = exp_q.pop_front();
      if (!ce.rst) begin
        m_stall = 0;
        m_lu = 0;
      end
      check({ce.name, "_d0"}, id_rd_data[31:0], ce.e0);
      check({ce.name, "_d1"}, id_rd_data[63:32], ce.e1);
      check({ce.name, "_stall"}, {31'b0, stall}, {31'b0, ce.estall});
      check({ce.name, "_full"}, {31'b0, lr_full}, {31'b0, ce.efull});
      check({ce.name, "_scnt"}, stall_cnt, 32'(m_stall));
      check({ce.name, "_lucnt"}, lu_stall_cnt, 32'(m_lu));
`ifdef ID_FWD_STATS_EN
      if (ce.rst && ce.estall) m_stall++;
      if (ce.rst && ce.estall && ce.elu) m_lu++;
`endif
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0; id_valid = 1'b0; id_rd_en = '0; id_rd_addr = '0; id_rf_data = '0;
    id_wr_en = 1'b0; id_wr_addr = '0; id_is_long = 1'b0; st_wr_en = '0; st_wr_addr = '0;
    st_wr_data = '0; st_data_ok = '1; lr_done = 1'b0; lr_done_addr = '0; lr_done_data = '0;

    // Reset holds outputs at zero even with a would-be load-use hazard present.
    v = idle("rst"); v.rst = 1'b0; v.rd_en = 2'b11; v.a0 = 5'd3; v.a1 = 5'd4;
    v.st_en = 2'b01; v.s0a = 5'd3; v.s0d = 32'h33; v.ok = 2'b10; apply(v);

    v = idle("rf_pass"); v.rd_en = 2'b11; v.a0 = 5'd3; v.a1 = 5'd4;
    v.e0 = 32'hAAAA_0000; v.e1 = 32'hBBBB_0000; tbl.push_back(v);
    v = idle("prio_st0"); v.st_en = 2'b11; v.s0a = 5'd5; v.s0d = 32'h11; v.s1a = 5'd5; v.s1d = 32'h22;
    v.rd_en = 2'b01; v.a0 = 5'd5; v.e0 = 32'h11; tbl.push_back(v);
    v = idle("prio_st1"); v.st_en = 2'b10; v.s0a = 5'd5; v.s0d = 32'h11; v.s1a = 5'd5; v.s1d = 32'h22;
    v.rd_en = 2'b01; v.a0 = 5'd5; v.e0 = 32'h22; tbl.push_back(v);
    v = idle("split_match"); v.st_en = 2'b11; v.s0a = 5'd6; v.s0d = 32'h66; v.s1a = 5'd5; v.s1d = 32'h22;
    v.rd_en = 2'b11; v.a0 = 5'd5; v.a1 = 5'd6; v.e0 = 32'h22; v.e1 = 32'h66; tbl.push_back(v);
    v = idle("r0_zero"); v.st_en = 2'b01; v.s0a = 5'd0; v.s0d = 32'hFFFF; v.rd_en = 2'b11; tbl.push_back(v);
    v = idle("lr_fwd"); v.done = 1'b1; v.done_addr = 5'd8; v.done_data = 32'h88;
    v.rd_en = 2'b01; v.a0 = 5'd8; v.e0 = 32'h88; tbl.push_back(v);
    v = idle("stage_over_lr"); v.done = 1'b1; v.done_addr = 5'd8; v.done_data = 32'h88;
    v.st_en = 2'b10; v.s1a = 5'd8; v.s1d = 32'h99; v.rd_en = 2'b10; v.a1 = 5'd8; v.e1 = 32'h99; tbl.push_back(v);
    v = idle("rd_en_off"); v.st_en = 2'b01; v.s0a = 5'd5; v.s0d = 32'h11; v.a0 = 5'd5; v.a1 = 5'd5; tbl.push_back(v);
    v = idle("invalid_no_stall"); v.valid = 1'b0; v.st_en = 2'b01; v.s0a = 5'd7; v.s0d = 32'h70; v.ok = 2'b10;
    v.rd_en = 2'b01; v.a0 = 5'd7; v.e0 = 32'h70; tbl.push_back(v);
    v = idle("lu_young_ok"); v.st_en = 2'b11; v.s0a = 5'd7; v.s0d = 32'h71; v.s1a = 5'd7; v.s1d = 32'h72;
    v.ok = 2'b01; v.rd_en = 2'b01; v.a0 = 5'd7; v.e0 = 32'h71; tbl.push_back(v);
    v = idle("lu_st1"); v.st_en = 2'b10; v.s1a = 5'd7; v.s1d = 32'h72; v.ok = 2'b01;
    v.rd_en = 2'b01; v.a0 = 5'd7; v.e0 = 32'h72; v.estall = 1'b1; v.elu = 1'b1; tbl.push_back(v);

    for (int i = 0; i < tbl.size(); i++) apply(tbl[i]);

    v = idle("rst2"); v.rst = 1'b0; apply(v);

    // Load-use: three stalled cycles, then the load data arrives.
    for (int i = 0; i < 3; i++) begin
      v = idle("lu_wait"); v.st_en = 2'b01; v.s0a = 5'd7; v.ok = 2'b10;
      v.rd_en = 2'b10; v.a1 = 5'd7; v.estall = 1'b1; v.elu = 1'b1; apply(v);
    end
    v = idle("lu_ready"); v.st_en = 2'b01; v.s0a = 5'd7; v.s0d = 32'hAB;
    v.rd_en = 2'b10; v.a1 = 5'd7; v.e1 = 32'hAB; apply(v);

    // RAW on a long-latency destination.
    v = idle("raw_issue"); v.wr_en = 1'b1; v.wr_addr = 5'd9; v.is_long = 1'b1; apply(v);
    for (int i = 0; i < 2; i++) begin
      v = idle("raw_wait"); v.rd_en = 2'b01; v.a0 = 5'd9; v.e0 = 32'hAAAA_0000; v.estall = 1'b1; apply(v);
    end
    v = idle("raw_done"); v.rd_en = 2'b01; v.a0 = 5'd9; v.done = 1'b1; v.done_addr = 5'd9;
    v.done_data = 32'h55; v.e0 = 32'h55; apply(v);
    v = idle("raw_clear"); v.rd_en = 2'b01; v.a0 = 5'd9; v.e0 = 32'hAAAA_0000; apply(v);
    @(negedge clk);
`ifdef ID_FWD_STATS_EN
    check("stats_total", stall_cnt, 32'd5);
    check("stats_lu", lu_stall_cnt, 32'd3);
`else
    check("stats_total_off", stall_cnt, 32'd0);
    check("stats_lu_off", lu_stall_cnt, 32'd0);
`endif

    // Fill the long-latency queue.
    for (int i = 1; i <= 4; i++) begin
      v = idle("fill"); v.wr_en = 1'b1; v.wr_addr = 5'(i); v.is_long = 1'b1; apply(v);
    end
    v = idle("full_stall"); v.wr_en = 1'b1; v.wr_addr = 5'd10; v.is_long = 1'b1;
    v.estall = 1'b1; v.efull = 1'b1; apply(v);
    v = idle("full_swap"); v.wr_en = 1'b1; v.wr_addr = 5'd10; v.is_long = 1'b1; v.done = 1'b1;
    v.done_addr = 5'd2; v.done_data = 32'h22; v.rd_en = 2'b01; v.a0 = 5'd2; v.e0 = 32'h22; v.efull = 1'b1; apply(v);
    v = idle("waw"); v.wr_en = 1'b1; v.wr_addr = 5'd3; v.estall = 1'b1; v.efull = 1'b1; apply(v);
    v = idle("full_invalid"); v.valid = 1'b0; v.wr_en = 1'b1; v.wr_addr = 5'd11; v.is_long = 1'b1;
    v.efull = 1'b1; apply(v);
    v = idle("drain_r4"); v.done = 1'b1; v.done_addr = 5'd4; v.efull = 1'b1; apply(v);

    // Reset with r1, r3, r10 pending.
    v = idle("rst_mid"); v.rst = 1'b0; v.rd_en = 2'b11; v.a0 = 5'd1; v.a1 = 5'd3;
    v.st_en = 2'b01; v.s0a = 5'd1; v.s0d = 32'h1234; apply(v);
    v = idle("post_rst"); v.rd_en = 2'b11; v.a0 = 5'd1; v.a1 = 5'd3;
    v.e0 = 32'hAAAA_0000; v.e1 = 32'hBBBB_0000; apply(v);
    v = idle("late_done"); v.done = 1'b1; v.done_addr = 5'd10; v.done_data = 32'h1010;
    v.rd_en = 2'b01; v.a0 = 5'd10; v.e0 = 32'h1010; apply(v);
    v = idle("long_r0"); v.wr_en = 1'b1; v.wr_addr = 5'd0; v.is_long = 1'b1; apply(v);
    v = idle("read_r0"); v.rd_en = 2'b11; apply(v);
    for (int i = 11; i <= 14; i++) begin
      v = idle("refill"); v.wr_en = 1'b1; v.wr_addr = 5'(i); v.is_long = 1'b1; apply(v);
    end
    v = idle("refull"); v.efull = 1'b1; apply(v);
    v = idle("raw_other"); v.done = 1'b1; v.done_addr = 5'd11; v.rd_en = 2'b01; v.a0 = 5'd12;
    v.e0 = 32'hAAAA_0000; v.estall = 1'b1; v.efull = 1'b1; apply(v);

    repeat (2) @(negedge clk);
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
